// File: rtl/logic_unit_arbiter.sv
// rtl/logic_unit_arbiter.sv - round-robin arbiter time-multiplexing one bitwise logic unit
// Optional build macro: LOGIC_ARB_STATS_EN (per-requester grant counters, stats_clr, grant_count)
module logic_unit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [2*NUM_REQ-1:0]       req_op,
    input  logic [WIDTH*NUM_REQ-1:0]   req_a,
    input  logic [WIDTH*NUM_REQ-1:0]   req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [WIDTH-1:0]           rsp_data,
    output logic                       rsp_zero
`ifdef LOGIC_ARB_STATS_EN
    ,
    input  logic                       stats_clr,
    output logic [16*NUM_REQ-1:0]      grant_count
`endif
);

    localparam logic [1:0] OP_AND  = 2'b00;
    localparam logic [1:0] OP_OR   = 2'b01;
    localparam logic [1:0] OP_XOR  = 2'b10;
    localparam logic [1:0] OP_ANDN = 2'b11;

    logic [IDW-1:0]   ptr_q, ptr_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic             rsp_zero_q, rsp_zero_d;

    logic             can_accept;
    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW-1:0]   scan_idx;
    logic             transfer;
    logic [1:0]       sel_op;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] result;

    // The result register can take a new value when empty or being drained this cycle.
    assign can_accept = !rsp_valid_q || rsp_ready;

    // Round-robin search: first valid requester at or after ptr, wrapping modulo NUM_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // Nothing is granted while reset is asserted, so a request held through reset is never taken.
    assign transfer  = grant_found && can_accept && reset_n;
    assign req_ready = transfer ? (NUM_REQ'(1) << grant_idx) : '0;

    // Steer the winner's op and operands into the shared gate array.
    always_comb begin
        sel_op = OP_AND;
        sel_a  = '0;
        sel_b  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_op = req_op[2*i +: 2];
                sel_a  = req_a[WIDTH*i +: WIDTH];
                sel_b  = req_b[WIDTH*i +: WIDTH];
            end
        end
    end

    // Per-bit logic unit; no carries cross bit positions.
    always_comb begin
        result = '0;
        case (sel_op)
            OP_AND:  result = sel_a & sel_b;
            OP_OR:   result = sel_a | sel_b;
            OP_XOR:  result = sel_a ^ sel_b;
            OP_ANDN: result = sel_a & ~sel_b;
            default: result = '0;
        endcase
    end

    // Result stage: reload on transfer (no bubble when draining at the same time), else drain.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        rsp_zero_d  = rsp_zero_q;
        ptr_d       = ptr_q;
        if (transfer) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant_idx;
            rsp_data_d  = result;
            rsp_zero_d  = (result == '0);
            ptr_d       = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // State registers; reset discards any pending result immediately.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            rsp_zero_q  <= rsp_zero_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;

`ifdef LOGIC_ARB_STATS_EN
    logic [15:0] cnt_q [NUM_REQ];
    logic [15:0] cnt_d [NUM_REQ];

    // Saturating grant counters; a clear in the same cycle as a transfer wins.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            cnt_d[i] = cnt_q[i];
            if (stats_clr) begin
                cnt_d[i] = '0;
            end else if (transfer && (grant_idx == IDW'(i)) && (cnt_q[i] != 16'hFFFF)) begin
                cnt_d[i] = cnt_q[i] + 16'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt_out
        assign grant_count[16*g +: 16] = cnt_q[g];
    end
`endif

endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
Shares one 32-bit bitwise logic unit between NUM_REQ requesters, e.g. ALU issue, branch-compare and plotter mask/stepper logic. The unit supports AND, OR, XOR and ANDN.
- Round-robin arbitration, valid/ready handshake on every requester.
- One registered result stage with backpressure.
- Sits beside the ALU; the logic unit is the per-bit gate array, and this block sequences and time-multiplexes it.

Parameters:
NUM_REQ, 4, number of requesters (2..8); id width IDW = clog2(NUM_REQ), minimum 1
WIDTH, 32, operand/result width

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
req_valid  input  NUM_REQ  per-requester request valid
req_ready  output  NUM_REQ  per-requester accept (one-hot or zero)
req_op  input  2*NUM_REQ  op of requester i in bits [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 ANDN (a & ~b)
req_a  input  WIDTH*NUM_REQ  operand A of requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i]
req_b  input  WIDTH*NUM_REQ  operand B, same packing
rsp_valid  output  1  result register holds a valid result
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  index of requester that issued the result
rsp_data  output  WIDTH  result
rsp_zero  output  1  rsp_data == 0

Behaviour:
- Reset (reset_n low, async): rsp_valid=0, rsp_id=0, rsp_data=0, rsp_zero=0. Round-robin pointer is 0, meaning requester 0 has top priority. req_ready=0 while reset_n is low.
- Accept condition: can_accept = !rsp_valid | rsp_ready.
- Grant, combinational:
  - Search req_valid starting at index ptr and wrapping modulo NUM_REQ.
  - The first set bit wins.
  - req_ready[i]=1 only for the winner, and only when can_accept=1.
  - No requester ready → req_ready all 0.
- Transfer: request i transfers on a clock edge where req_valid[i] & req_ready[i]. At most one transfer per cycle.
- On transfer:
  - rsp_data <= op(a_i, b_i)
  - rsp_id <= i
  - rsp_zero <= (result == 0)
  - rsp_valid <= 1
  - ptr <= (i+1) mod NUM_REQ
- Latency: result visible one cycle after the accepting edge. Throughput is 1/cycle while rsp_ready stays high.
- Consume without new transfer: rsp_valid & rsp_ready with no transfer → rsp_valid <= 0. rsp_data, rsp_id and rsp_zero hold their last values.
- Simultaneous consume and transfer: the register reloads and rsp_valid stays 1. There is no bubble.
- Stall: rsp_valid & !rsp_ready → all outputs hold, req_ready=0, ptr holds.
- Requester obligations: hold req_op, req_a and req_b stable while req_valid is high and not yet accepted. The arbiter never drops an accepted request.
- Fairness: any continuously valid requester is granted within NUM_REQ accepting cycles.
- ptr changes only on transfer. An idle cycle leaves ptr unchanged.
- Wrap-around: a grant to NUM_REQ-1 sets ptr to 0.
- Async reset mid-operation: a pending result is discarded and rsp_valid drops immediately. A request presented during reset is not accepted.
- The op decode is purely bitwise per bit. There is no carry and no width extension.

Optional Feature:
LOGIC_ARB_STATS_EN
- Defined:
  - Adds output grant_count, width 16*NUM_REQ, one 16-bit counter per requester.
  - Counter i increments on each transfer from requester i and saturates at 16'hFFFF.
  - Counters reset to 0 asynchronously.
  - Adds input stats_clr, 1 bit, a synchronous clear of all counters. If stats_clr coincides with a transfer, clear wins.
- Not defined: neither port exists and no counter logic is generated.

Test Plan:
1. Single request, no contention:
   - Stimulus: req 2 valid, op=00, a=32'hF0F0_1234, b=32'h0FF0_FFFF, rsp_ready=1.
   - Response: req_ready=4'b0100 in the same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=32'h00F0_1234, rsp_zero=0.
2. Round-robin with all four valid continuously, rsp_ready=1:
   - Response: grant order 0,1,2,3,0.
   - Then, with only reqs 1 and 3 valid after ptr=1: grants 1,3,1,3.
3. Backpressure:
   - Stimulus: req 0 result pending, rsp_ready=0 for 3 cycles, req 1 valid.
   - Response: req_ready=0, rsp_data and rsp_id held for 3 cycles; rsp_ready=1 → req 1 accepted the same cycle and its result appears next cycle with no bubble.
4. Op coverage and zero flag, with a=32'hAAAA_AAAA, b=32'hFFFF_0000:
   - OR → 32'hFFFF_AAAA
   - XOR → 32'h5555_AAAA
   - ANDN → 32'h0000_AAAA
   - AND of a and ~a → 0 with rsp_zero=1
5. Async reset mid-operation: reset_n low while rsp_valid=1 → rsp_valid=0 immediately, without waiting for a clock edge; after release the first grant goes to requester 0.
6. With LOGIC_ARB_STATS_EN:
   - Stimulus: 70000 back-to-back req 3 transfers, then stats_clr.
   - Response: grant_count[63:48] saturates at 16'hFFFF and the other counters read 0; after stats_clr all counters read 0.
